// File: rtl/car_dash_pkg.sv
// Shared types and constants for the Car Dash game-step sequencer.
package car_dash_pkg;

  localparam int unsigned LANES    = 6;
  localparam logic [2:0]  MAX_LANE = 3'd5;

  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;

  localparam int unsigned COLLIDE_BIT = 2;

  typedef enum logic [2:0] {
    StIdle,
    StRunWait,
    StStep,
    StWait1,
    StWait2,
    StApply,
    StOver
  } seq_state_e;

  // Lane update for one applied move. MOVE_LEFT raises the lane index and
  // MOVE_RIGHT lowers it. Both saturate at the road edges.
  function automatic logic [2:0] next_pos(input logic [2:0] pos, input logic [1:0] mv);
    logic [2:0] res;
    res = pos;
    if (mv == MOVE_LEFT) begin
      res = (pos == MAX_LANE) ? pos : pos + 3'd1;
    end else if (mv == MOVE_RIGHT) begin
      res = (pos == 3'd0) ? pos : pos - 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/car_dash_step_sequencer_if.sv
// Interface carrying the signals between the sequencer and the checker,
// the obstacle generator, the debouncer and the display driver.
interface car_dash_step_sequencer_if #(
  parameter int unsigned ROW_DEPTH = 8
);
  import car_dash_pkg::*;

  logic                       start;
  logic                       pause;
  logic [LANES-1:0]           new_row;
  logic [2:0]                 move_result;
  logic                       step;
  logic [2:0]                 position;
  logic [LANES-1:0]           head_row;
  logic [LANES-1:0]           next_row;
  logic [LANES*ROW_DEPTH-1:0] field;
  logic                       new_row_req;
  logic [1:0]                 lives;
  logic [15:0]                score;
  logic                       game_over;

  modport master (
    input  start, pause, new_row, move_result,
    output step, position, head_row, next_row, field, new_row_req, lives, score, game_over
  );

  modport slave (
    output start, pause, new_row, move_result,
    input  step, position, head_row, next_row, field, new_row_req, lives, score, game_over
  );

endinterface

// File: rtl/car_dash_row_field.sv
// Obstacle field buffer. Row 0 is beside the car. New rows enter at the far end.
module car_dash_row_field
  import car_dash_pkg::*;
#(
  parameter int unsigned ROW_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic [LANES-1:0]           row_in,
  output logic [LANES*ROW_DEPTH-1:0] field,
  output logic [LANES-1:0]           head_row,
  output logic [LANES-1:0]           next_row
);

  logic [ROW_DEPTH-1:0][LANES-1:0] rows_q;

  // Clear has priority. A shift scrolls every row one step towards the car.
  always_ff @(posedge clk) begin
    if (clear) begin
      rows_q <= '0;
    end else if (shift_en) begin
      rows_q <= {row_in, rows_q[ROW_DEPTH-1:1]};
    end
  end

  assign field    = rows_q;
  assign head_row = rows_q[0];
  assign next_row = rows_q[1];

endmodule

// File: rtl/car_dash_step_sequencer.sv
// Game-step controller: paces ticks, strobes the checker and applies its result.
module car_dash_step_sequencer
  import car_dash_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned START_POS   = 2,
  parameter int unsigned ROW_DEPTH   = 8
) (
  input logic                      clk,
  input logic                      reset,
  car_dash_step_sequencer_if.master bus
);

  localparam int unsigned     CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  seq_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            step_q;
  logic            req_q;
  logic            over_q;
  logic [2:0]      pos_q;
  logic [1:0]      lives_q;
  logic [15:0]     score_q;

  logic restart;
  logic fatal;
  logic field_clear;
  logic field_shift;

  // Restart, last-life detection and field control for the current cycle.
  always_comb begin
    restart     = ((state_q == StIdle) || (state_q == StOver)) && bus.start;
    fatal       = bus.move_result[COLLIDE_BIT] && (lives_q == 2'd1);
    field_clear = !reset || restart;
    field_shift = reset && (state_q == StApply) && !fatal;
  end

  // Game sequencer. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      req_q   <= 1'b0;
      over_q  <= 1'b0;
      pos_q   <= 3'(START_POS);
      lives_q <= 2'(START_LIVES);
      score_q <= '0;
    end else begin
      step_q <= 1'b0;
      req_q  <= 1'b0;
      unique case (state_q)
        StIdle, StOver: begin
          if (restart) begin
            state_q <= StRunWait;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            pos_q   <= 3'(START_POS);
            lives_q <= 2'(START_LIVES);
            score_q <= '0;
          end
        end
        StRunWait: begin
          if (!bus.pause) begin
            if (cnt_q == CntMax) begin
              cnt_q   <= '0;
              step_q  <= 1'b1;
              state_q <= StStep;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StStep:  state_q <= StWait1;
        StWait1: state_q <= StWait2;
        StWait2: begin
          // The request is raised for the whole APPLY cycle. The row is
          // taken on the edge that leaves APPLY.
          req_q   <= 1'b1;
          state_q <= StApply;
        end
        StApply: begin
          pos_q <= next_pos(pos_q, bus.move_result[1:0]);
          if (fatal) begin
            lives_q <= 2'd0;
            over_q  <= 1'b1;
            state_q <= StOver;
          end else begin
            if (bus.move_result[COLLIDE_BIT]) begin
              lives_q <= lives_q - 2'd1;
            end
            if (score_q != 16'hFFFF) begin
              score_q <= score_q + 16'd1;
            end
            state_q <= StRunWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  car_dash_row_field #(
    .ROW_DEPTH(ROW_DEPTH)
  ) u_row_field (
    .clk     (clk),
    .clear   (field_clear),
    .shift_en(field_shift),
    .row_in  (bus.new_row),
    .field   (bus.field),
    .head_row(bus.head_row),
    .next_row(bus.next_row)
  );

  assign bus.step        = step_q;
  assign bus.new_row_req = req_q;
  assign bus.game_over   = over_q;
  assign bus.position    = pos_q;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;

endmodule

// File: tb/tb_car_dash_step_sequencer.sv
// Scoreboard bench for car_dash_step_sequencer with TICK_DIV = 4.
module tb_car_dash_step_sequencer;
  import car_dash_pkg::*;

  localparam int unsigned Depth = 8;

  typedef struct packed {
    logic [7:0]  gap;
    logic        pause;
    logic [2:0]  mr;
    logic [5:0]  nr;
    logic [2:0]  pos;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        over;
    logic [5:0]  head;
    logic [5:0]  tail;
  } vec_t;

  typedef struct packed {
    logic [2:0]  pos;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        over;
    logic [5:0]  head;
    logic [5:0]  tail;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  car_dash_step_sequencer_if #(.ROW_DEPTH(Depth)) bus ();

  car_dash_step_sequencer #(
    .TICK_DIV   (4),
    .START_LIVES(3),
    .START_POS  (2),
    .ROW_DEPTH  (Depth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   vectors = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t game1[$];
  vec_t game2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input int gap, input logic pause, input logic [2:0] mr,
                              input logic [5:0] nr, input logic [2:0] pos,
                              input logic [1:0] lives, input int score, input logic over,
                              input logic [5:0] head, input logic [5:0] tail);
    vec_t v;
    v.gap = 8'(gap);
    v.pause = pause;
    v.mr = mr;
    v.nr = nr;
    v.pos = pos;
    v.lives = lives;
    v.score = 16'(score);
    v.over = over;
    v.head = head;
    v.tail = tail;
    return v;
  endfunction

  // Waits for a step strobe; n counts negedges from the call.
  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.step && n < budget);
    if (!bus.step) begin
      vectors++;
      errors++;
      $display("FAIL step_timeout: got no step in %0d cycles, expected one", budget);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    int seen;
    exp_t e;
    if (v.pause) begin
      repeat (5) @(negedge clk);
      bus.pause = 1'b1;
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.step) seen++;
      end
      check("pause_no_step", 64'(seen), 64'd0);
      bus.pause = 1'b0;
    end
    wait_step(40, n);
    check("step_gap", 64'(n), 64'(v.gap));
    bus.move_result = v.mr;
    bus.new_row = v.nr;
    e.pos = v.pos;
    e.lives = v.lives;
    e.score = v.score;
    e.over = v.over;
    e.head = v.head;
    e.tail = v.tail;
    exp_q.push_back(e);
  endtask

  // Monitor: strobe shape, request timing, and post-APPLY state.
  int   ncyc = 0;
  int   step_cyc = 0;
  logic step_prev = 1'b0;
  logic req_prev = 1'b0;
  exp_t got;

  initial begin : monitor
    forever begin
      @(negedge clk);
      ncyc++;
      if (step_prev) check("step_width", 64'(bus.step), 64'd0);
      if (bus.step && !step_prev) step_cyc = ncyc;
      if (bus.new_row_req && !req_prev) check("req_in_apply", 64'(ncyc - step_cyc), 64'd3);
      if (req_prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_apply: got an APPLY, expected none");
        end else begin
          got = exp_q.pop_front();
          check("position", 64'(bus.position), 64'(got.pos));
          check("lives", 64'(bus.lives), 64'(got.lives));
          check("score", 64'(bus.score), 64'(got.score));
          check("game_over", 64'(bus.game_over), 64'(got.over));
          check("head_row", 64'(bus.head_row), 64'(got.head));
          check("tail_row", 64'(bus.field[6*Depth-1 -: 6]), 64'(got.tail));
          check("req_width", 64'(bus.new_row_req), 64'd0);
        end
      end
      step_prev = bus.step;
      req_prev = bus.new_row_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n;
    int seen;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.new_row = '0;
    bus.move_result = '0;

    // gap, pause, mr, nr, pos, lives, score, over, head, tail
    game1.push_back(mk(4, 1'b0, 3'b010, 6'b100001, 3'd3, 2'd3, 1, 1'b0, 6'b000000, 6'b100001));
    game1.push_back(mk(8, 1'b0, 3'b010, 6'b000010, 3'd4, 2'd3, 2, 1'b0, 6'b000000, 6'b000010));
    game1.push_back(mk(8, 1'b0, 3'b010, 6'b000100, 3'd5, 2'd3, 3, 1'b0, 6'b000000, 6'b000100));
    game1.push_back(mk(8, 1'b0, 3'b010, 6'b001000, 3'd5, 2'd3, 4, 1'b0, 6'b000000, 6'b001000));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b010000, 3'd4, 2'd3, 5, 1'b0, 6'b000000, 6'b010000));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b000011, 3'd3, 2'd3, 6, 1'b0, 6'b000000, 6'b000011));
    game1.push_back(mk(8, 1'b0, 3'b011, 6'b000110, 3'd3, 2'd3, 7, 1'b0, 6'b000000, 6'b000110));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b001100, 3'd2, 2'd3, 8, 1'b0, 6'b100001, 6'b001100));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b011000, 3'd1, 2'd3, 9, 1'b0, 6'b000010, 6'b011000));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b110000, 3'd0, 2'd3, 10, 1'b0, 6'b000100, 6'b110000));
    game1.push_back(mk(8, 1'b0, 3'b001, 6'b100100, 3'd0, 2'd3, 11, 1'b0, 6'b001000, 6'b100100));
    game1.push_back(mk(3, 1'b1, 3'b100, 6'b000001, 3'd0, 2'd2, 12, 1'b0, 6'b010000, 6'b000001));
    game1.push_back(mk(8, 1'b0, 3'b110, 6'b000010, 3'd1, 2'd1, 13, 1'b0, 6'b000011, 6'b000010));
    game1.push_back(mk(8, 1'b0, 3'b101, 6'b111111, 3'd0, 2'd0, 13, 1'b1, 6'b000011, 6'b000010));
    game2.push_back(mk(4, 1'b0, 3'b000, 6'b101010, 3'd2, 2'd3, 1, 1'b0, 6'b000000, 6'b101010));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_step", 64'(bus.step), 64'd0);
    check("rst_req", 64'(bus.new_row_req), 64'd0);
    check("rst_over", 64'(bus.game_over), 64'd0);
    check("rst_position", 64'(bus.position), 64'd2);
    check("rst_lives", 64'(bus.lives), 64'd3);
    check("rst_score", 64'(bus.score), 64'd0);
    check("rst_field", 64'(bus.field), 64'd0);

    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    foreach (game1[i]) run_vec(game1[i]);

    // Game over: no strobes, state frozen
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.step) seen++;
    end
    check("over_no_step", 64'(seen), 64'd0);
    check("over_flag", 64'(bus.game_over), 64'd1);
    check("over_pos_hold", 64'(bus.position), 64'd0);
    check("over_score_hold", 64'(bus.score), 64'd13);

    // Restart from OVER
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_lives", 64'(bus.lives), 64'd3);
    check("restart_over", 64'(bus.game_over), 64'd0);
    check("restart_position", 64'(bus.position), 64'd2);
    check("restart_score", 64'(bus.score), 64'd0);
    check("restart_field", 64'(bus.field), 64'd0);
    foreach (game2[i]) run_vec(game2[i]);

    // Reset during WAIT1, with a move presented that must be ignored
    wait_step(40, n);
    check("step_gap", 64'(n), 64'd8);
    bus.move_result = 3'b010;
    bus.new_row = 6'b111000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_step", 64'(bus.step), 64'd0);
    check("midrst_position", 64'(bus.position), 64'd2);
    check("midrst_lives", 64'(bus.lives), 64'd3);
    check("midrst_score", 64'(bus.score), 64'd0);
    check("midrst_field", 64'(bus.field), 64'd0);
    check("midrst_over", 64'(bus.game_over), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.step || bus.new_row_req) seen++;
    end
    check("idle_no_activity", 64'(seen), 64'd0);
    check("idle_position", 64'(bus.position), 64'd2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
